// File: rtl/niospherisys_cpu_oci_dct_packer.sv
// niospherisys_cpu_oci_dct_packer: packs 2-bit branch-outcome codes into a
// 30-bit buffer of up to 15 entries and emits 36-bit trace frames over a
// valid/ready handshake. The buffer/count pair is visible live.
// Optional feature: define NIOSPHERISYS_DCT_DROP_CNT_EN to add an 8-bit
// saturating dropped-frame counter (dct_drop_cnt).
module niospherisys_cpu_oci_dct_packer #(
  parameter int unsigned DCT_DEPTH = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trc_on,
  input  logic        dct_valid,
  input  logic [1:0]  dct_code,
  input  logic        dct_flush,
  input  logic        frame_ready,
  output logic        frame_valid,
  output logic [35:0] frame_data,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
`ifdef NIOSPHERISYS_DCT_DROP_CNT_EN
  output logic [7:0]  dct_drop_cnt,
`endif
  output logic        dct_overflow
);

  logic        trc_on_q;
  logic        acc;
  logic        flush;
  logic        emit;
  logic        load;
  logic        drop;
  logic [29:0] buf_next;
  logic [3:0]  cnt_next;

  // Accept/flush decode and post-accept contents of the buffer.
  always_comb begin
    acc      = trc_on & dct_valid & ((dct_code == 2'b01) | (dct_code == 2'b10));
    flush    = dct_flush | (trc_on_q & ~trc_on);
    buf_next = dct_buffer;
    cnt_next = dct_count;
    if (acc) begin
      buf_next = {dct_buffer[27:0], dct_code};
      cnt_next = dct_count + 4'd1;
    end
    // A code that completes the buffer and a flush in the same cycle share
    // one emission, so a full frame is never followed by an empty one.
    emit = (acc & (dct_count == 4'(DCT_DEPTH - 1))) |
           (flush & ((dct_count != '0) | acc));
    load = emit & (~frame_valid | frame_ready);
    drop = emit & frame_valid & ~frame_ready;
  end

  // Accumulation buffer, entry count and previous trace-enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dct_buffer <= '0;
      dct_count  <= '0;
      trc_on_q   <= 1'b0;
    end else begin
      trc_on_q <= trc_on;
      if (emit) begin
        dct_buffer <= '0;
        dct_count  <= '0;
      end else begin
        dct_buffer <= buf_next;
        dct_count  <= cnt_next;
      end
    end
  end

  // Single-entry frame register; reloads in the same cycle it drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_valid <= 1'b0;
      frame_data  <= '0;
    end else if (load) begin
      frame_valid <= 1'b1;
      frame_data  <= {cnt_next, 2'b00, buf_next};
    end else if (frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

`ifdef NIOSPHERISYS_DCT_DROP_CNT_EN
  // Saturating count of frames dropped while the register was stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dct_drop_cnt <= '0;
    end else if (drop && (dct_drop_cnt != '1)) begin
      dct_drop_cnt <= dct_drop_cnt + 8'd1;
    end
  end

  // Overflow is derived from the drop counter.
  always_comb begin
    dct_overflow = (dct_drop_cnt != '0);
  end
`else
  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dct_overflow <= 1'b0;
    end else if (drop) begin
      dct_overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_niospherisys_cpu_oci_dct_packer.sv
// Directed testbench for niospherisys_cpu_oci_dct_packer.
module tb_niospherisys_cpu_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        trc_on;
  logic        dct_valid;
  logic [1:0]  dct_code;
  logic        dct_flush;
  logic        frame_ready;
  logic        frame_valid;
  logic [35:0] frame_data;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_overflow;
`ifdef NIOSPHERISYS_DCT_DROP_CNT_EN
  logic [7:0]  dct_drop_cnt;
`endif

  int n_chk = 0;
  int n_bad = 0;

  niospherisys_cpu_oci_dct_packer #(.DCT_DEPTH(15)) dut (
    .clk          (clk),
    .reset        (reset),
    .trc_on       (trc_on),
    .dct_valid    (dct_valid),
    .dct_code     (dct_code),
    .dct_flush    (dct_flush),
    .frame_ready  (frame_ready),
    .frame_valid  (frame_valid),
    .frame_data   (frame_data),
    .dct_buffer   (dct_buffer),
    .dct_count    (dct_count),
`ifdef NIOSPHERISYS_DCT_DROP_CNT_EN
    .dct_drop_cnt (dct_drop_cnt),
`endif
    .dct_overflow (dct_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; trc_on = 1'b1; dct_valid = 1'b0; dct_code = 2'b00;
    dct_flush = 1'b0; frame_ready = 1'b1;
    #1;
    check("rst_valid", 64'(frame_valid), 64'd0);
    check("rst_data", 64'(frame_data), 64'd0);
    check("rst_count", 64'(dct_count), 64'd0);
    check("rst_buffer", 64'(dct_buffer), 64'd0);
    check("rst_ovf", 64'(dct_overflow), 64'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Full frame: 15 codes alternating 10,01 starting with 10.
    for (int i = 0; i < 15; i++) begin
      dct_valid = 1'b1;
      dct_code  = (i % 2 == 0) ? 2'b10 : 2'b01;
      tick();
      if (i == 13) check("full_cnt14", 64'(dct_count), 64'd14);
      if (i == 13) check("full_frame_not_yet", 64'(frame_valid), 64'd0);
    end
    dct_valid = 1'b0;
    check("full_valid", 64'(frame_valid), 64'd1);
    check("full_data", 64'(frame_data), 64'h0_0000_000F_2666_6666);
    check("full_cnt0", 64'(dct_count), 64'd0);
    tick();
    check("full_drained", 64'(frame_valid), 64'd0);

    // Partial flush of 10,10,01.
    dct_valid = 1'b1; dct_code = 2'b10; tick();
    dct_code = 2'b10; tick();
    dct_code = 2'b01; tick();
    dct_valid = 1'b0;
    check("part_cnt", 64'(dct_count), 64'd3);
    check("part_buf", 64'(dct_buffer), 64'h29);
    dct_flush = 1'b1; tick();
    check("part_valid", 64'(frame_valid), 64'd1);
    check("part_data", 64'(frame_data), 64'h3_0000_0029);
    check("part_cnt0", 64'(dct_count), 64'd0);
    tick();
    dct_flush = 1'b0;
    check("empty_flush", 64'(frame_valid), 64'd0);

    // Simultaneous accept and flush at count 14.
    for (int i = 0; i < 14; i++) begin
      dct_valid = 1'b1; dct_code = 2'b01; tick();
    end
    check("sim_cnt14", 64'(dct_count), 64'd14);
    dct_code = 2'b10; dct_flush = 1'b1; tick();
    dct_valid = 1'b0; dct_flush = 1'b0;
    check("sim_valid", 64'(frame_valid), 64'd1);
    check("sim_data", 64'(frame_data), 64'hF_1555_5556);
    check("sim_cnt0", 64'(dct_count), 64'd0);
    tick();
    check("sim_one_frame", 64'(frame_valid), 64'd0);

    // Back-pressure: first frame held, second dropped.
    frame_ready = 1'b0;
    dct_valid = 1'b1; dct_code = 2'b10; dct_flush = 1'b1; tick();
    dct_valid = 1'b0; dct_flush = 1'b0;
    check("bp_valid", 64'(frame_valid), 64'd1);
    check("bp_data", 64'(frame_data), 64'h1_0000_0002);
    tick();
    check("bp_hold", 64'(frame_data), 64'h1_0000_0002);
    check("bp_no_ovf", 64'(dct_overflow), 64'd0);
    dct_valid = 1'b1; dct_code = 2'b01; dct_flush = 1'b1; tick();
    dct_valid = 1'b0; dct_flush = 1'b0;
    check("bp_ovf", 64'(dct_overflow), 64'd1);
    check("bp_kept", 64'(frame_data), 64'h1_0000_0002);
    check("bp_cnt0", 64'(dct_count), 64'd0);
`ifdef NIOSPHERISYS_DCT_DROP_CNT_EN
    check("bp_dropcnt", 64'(dct_drop_cnt), 64'd1);
`endif
    frame_ready = 1'b1; tick();
    check("bp_drained", 64'(frame_valid), 64'd0);
    check("bp_ovf_sticky", 64'(dct_overflow), 64'd1);

    // Gating by trc_on and reserved codes.
    trc_on = 1'b0; dct_valid = 1'b1; dct_code = 2'b10; tick();
    check("gate_off", 64'(dct_count), 64'd0);
    check("gate_nofrm", 64'(frame_valid), 64'd0);
    trc_on = 1'b1; dct_code = 2'b11; tick();
    check("gate_rsvd", 64'(dct_count), 64'd0);
    for (int i = 0; i < 5; i++) begin
      dct_code = 2'b10; tick();
    end
    dct_valid = 1'b0;
    check("gate_cnt5", 64'(dct_count), 64'd5);
    trc_on = 1'b0; tick();
    check("fall_valid", 64'(frame_valid), 64'd1);
    check("fall_data", 64'(frame_data), 64'h5_0000_02AA);
    check("fall_cnt0", 64'(dct_count), 64'd0);
    tick();

    // Asynchronous reset mid-operation.
    trc_on = 1'b1; frame_ready = 1'b0;
    dct_valid = 1'b1; dct_code = 2'b01; dct_flush = 1'b1; tick();
    dct_flush = 1'b0;
    for (int i = 0; i < 7; i++) begin
      dct_code = 2'b10; tick();
    end
    dct_valid = 1'b0;
    check("mid_cnt7", 64'(dct_count), 64'd7);
    check("mid_valid", 64'(frame_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 64'(frame_valid), 64'd0);
    check("arst_data", 64'(frame_data), 64'd0);
    check("arst_cnt", 64'(dct_count), 64'd0);
    check("arst_buf", 64'(dct_buffer), 64'd0);
    check("arst_ovf", 64'(dct_overflow), 64'd0);
`ifdef NIOSPHERISYS_DCT_DROP_CNT_EN
    check("arst_dropcnt", 64'(dct_drop_cnt), 64'd0);
`endif
    #1 reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
